// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        VBUSY = 1'b1
    } hz_state_t;

    localparam int VLAT_MAX = 16;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side view of the hazard controller: register tags in, stall/flush/forward controls out.
interface hazard_if #(
    parameter int REG_W = 4
);
    import hazard_pkg::*;

    logic [REG_W-1:0] rs1_d, rs2_d;
    logic [REG_W-1:0] rs1_e, rs2_e;
    logic [REG_W-1:0] rd_e, rd_m, rd_w;
    logic             regwrite_e, regwrite_m, regwrite_w;
    logic             memtoreg_e;
    logic             vop_e;
    logic             branch_taken_e;
    logic             stall_f, stall_d, stall_e;
    logic             flush_d, flush_e, flush_m;
    fwd_sel_t         fwd_a_e, fwd_b_e;
    logic             vbusy;

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  regwrite_e, regwrite_m, regwrite_w,
        input  memtoreg_e, vop_e, branch_taken_e,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
        output fwd_a_e, fwd_b_e, vbusy
    );

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output regwrite_e, regwrite_m, regwrite_w,
        output memtoreg_e, vop_e, branch_taken_e,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
        input  fwd_a_e, fwd_b_e, vbusy
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward select for one E-stage operand; M stage wins over W, register 0 never matches.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rd_m_i,
    input  logic [REG_W-1:0] rd_w_i,
    input  logic             regwrite_m_i,
    input  logic             regwrite_w_i,
    output fwd_sel_t         sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        if (rs_i != '0) begin
            if (regwrite_m_i && (rd_m_i == rs_i)) begin
                sel_o = FWD_MEM;
            end else if (regwrite_w_i && (rd_w_i == rs_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, taken-branch flush, vector-op E occupancy and operand forwarding.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int VLAT  = 4
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);

    localparam int CNT_W = $clog2(VLAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(VLAT - 2);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fwd_sel_t         sel_a, sel_b;
    logic             lwstall;

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .rs_i         (hz.rs1_e),
        .rd_m_i       (hz.rd_m),
        .rd_w_i       (hz.rd_w),
        .regwrite_m_i (hz.regwrite_m),
        .regwrite_w_i (hz.regwrite_w),
        .sel_o        (sel_a)
    );

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .rs_i         (hz.rs2_e),
        .rd_m_i       (hz.rd_m),
        .rd_w_i       (hz.rd_w),
        .regwrite_m_i (hz.regwrite_m),
        .regwrite_w_i (hz.regwrite_w),
        .sel_o        (sel_b)
    );

    assign lwstall = hz.memtoreg_e && (hz.rd_e != '0) &&
                     ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hz.stall_f = 1'b0;
        hz.stall_d = 1'b0;
        hz.stall_e = 1'b0;
        hz.flush_d = 1'b0;
        hz.flush_e = 1'b0;
        hz.flush_m = 1'b0;
        hz.vbusy   = 1'b0;
        hz.fwd_a_e = FWD_NONE;
        hz.fwd_b_e = FWD_NONE;
        if (!reset) begin
            hz.fwd_a_e = sel_a;
            hz.fwd_b_e = sel_b;
            unique case (state_q)
                IDLE: begin
                    // Taken branch redirects fetch, so it must not be held by a load-use stall.
                    if (hz.branch_taken_e) begin
                        hz.flush_d = 1'b1;
                        hz.flush_e = 1'b1;
                    end else if (lwstall) begin
                        hz.stall_f = 1'b1;
                        hz.stall_d = 1'b1;
                        hz.flush_e = 1'b1;
                    end
                    if (hz.vop_e) begin
                        state_d = VBUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
                VBUSY: begin
                    hz.stall_f = 1'b1;
                    hz.stall_d = 1'b1;
                    hz.stall_e = 1'b1;
                    hz.flush_m = 1'b1;
                    hz.vbusy   = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (VLAT=4): forwarding, load-use, branch priority, vector occupancy, reset.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    hazard_if #(.REG_W(4)) hz ();

    hazard_ctrl #(.REG_W(4), .VLAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, vbusy}
    logic [6:0] ctl;
    assign ctl = {hz.stall_f, hz.stall_d, hz.stall_e,
                  hz.flush_d, hz.flush_e, hz.flush_m, hz.vbusy};

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0001100;
    localparam logic [6:0] C_BUSY = 7'b1110011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0;
        hz.rd_e = '0; hz.rd_m = '0; hz.rd_w = '0;
        hz.regwrite_e = 1'b0; hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0;
        hz.memtoreg_e = 1'b0; hz.vop_e = 1'b0; hz.branch_taken_e = 1'b0;
    endtask

    task automatic next_step();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_inputs();

        // Reset with hazard-provoking inputs: everything must read zero.
        @(negedge clk);
        hz.memtoreg_e = 1'b1; hz.rd_e = 4'd5; hz.rs2_d = 4'd5;
        hz.rs1_e = 4'd3; hz.rd_m = 4'd3; hz.regwrite_m = 1'b1; hz.vop_e = 1'b1;
        #1;
        chk("reset_ctl", {1'b0, ctl}, {1'b0, C_NONE});
        chk("reset_fwd_a", {6'd0, hz.fwd_a_e}, {6'd0, FWD_NONE});

        next_step();
        reset = 1'b0;
        #1;
        chk("idle_after_reset", {1'b0, ctl}, {1'b0, C_NONE});

        // Forwarding
        next_step();
        hz.rs1_e = 4'd3; hz.rd_m = 4'd3; hz.regwrite_m = 1'b1;
        hz.rd_w = 4'd3; hz.regwrite_w = 1'b1; hz.rs2_e = 4'd7;
        #1;
        chk("fwd_a_mem_prio", {6'd0, hz.fwd_a_e}, {6'd0, 2'b10});
        chk("fwd_b_nomatch", {6'd0, hz.fwd_b_e}, {6'd0, 2'b00});
        hz.regwrite_m = 1'b0;
        #1;
        chk("fwd_a_wb", {6'd0, hz.fwd_a_e}, {6'd0, 2'b01});
        hz.rs2_e = 4'd3;
        #1;
        chk("fwd_b_wb", {6'd0, hz.fwd_b_e}, {6'd0, 2'b01});
        hz.rs1_e = 4'd0; hz.rd_m = 4'd0; hz.rd_w = 4'd0;
        hz.regwrite_m = 1'b1; hz.regwrite_w = 1'b1;
        #1;
        chk("fwd_a_zero_reg", {6'd0, hz.fwd_a_e}, {6'd0, 2'b00});

        // Load-use
        next_step();
        hz.memtoreg_e = 1'b1; hz.rd_e = 4'd5; hz.rs2_d = 4'd5;
        #1;
        chk("lwstall", {1'b0, ctl}, {1'b0, C_LW});
        next_step();
        #1;
        chk("lwstall_one_cycle", {1'b0, ctl}, {1'b0, C_NONE});
        hz.memtoreg_e = 1'b1; hz.rd_e = 4'd0; hz.rs2_d = 4'd0;
        #1;
        chk("lwstall_rd0", {1'b0, ctl}, {1'b0, C_NONE});

        // Branch over load-use
        next_step();
        hz.memtoreg_e = 1'b1; hz.rd_e = 4'd6; hz.rs1_d = 4'd6; hz.branch_taken_e = 1'b1;
        #1;
        chk("branch_over_lw", {1'b0, ctl}, {1'b0, C_BR});

        // Vector op: one IDLE cycle then three VBUSY cycles
        next_step();
        hz.vop_e = 1'b1;
        #1;
        chk("vop_first_cycle", {1'b0, ctl}, {1'b0, C_NONE});
        next_step();
        hz.rs1_e = 4'd3; hz.rd_m = 4'd3; hz.regwrite_m = 1'b1;
        #1;
        chk("vbusy_1", {1'b0, ctl}, {1'b0, C_BUSY});
        chk("vbusy_fwd_a", {6'd0, hz.fwd_a_e}, {6'd0, 2'b10});
        next_step();
        hz.branch_taken_e = 1'b1;
        hz.memtoreg_e = 1'b1; hz.rd_e = 4'd5; hz.rs2_d = 4'd5;
        #1;
        chk("vbusy_2_branch_ignored", {1'b0, ctl}, {1'b0, C_BUSY});
        next_step();
        #1;
        chk("vbusy_3", {1'b0, ctl}, {1'b0, C_BUSY});

        // Back-to-back: reload in the single IDLE cycle after exit
        next_step();
        hz.vop_e = 1'b1;
        #1;
        chk("b2b_idle_gap", {1'b0, ctl}, {1'b0, C_NONE});
        for (int i = 0; i < 3; i++) begin
            next_step();
            #1;
            chk($sformatf("b2b_busy_%0d", i), {1'b0, ctl}, {1'b0, C_BUSY});
        end
        next_step();
        #1;
        chk("b2b_exit", {1'b0, ctl}, {1'b0, C_NONE});

        // vop_e with load-use in the same cycle, then reset on the 2nd VBUSY cycle
        next_step();
        hz.vop_e = 1'b1; hz.memtoreg_e = 1'b1; hz.rd_e = 4'd9; hz.rs1_d = 4'd9;
        #1;
        chk("vop_plus_lw", {1'b0, ctl}, {1'b0, C_LW});
        next_step();
        #1;
        chk("vbusy_pre_reset", {1'b0, ctl}, {1'b0, C_BUSY});
        next_step();
        reset = 1'b1;
        hz.rs1_e = 4'd3; hz.rd_m = 4'd3; hz.regwrite_m = 1'b1;
        #1;
        chk("reset_mid_ctl", {1'b0, ctl}, {1'b0, C_NONE});
        chk("reset_mid_fwd", {6'd0, hz.fwd_a_e}, {6'd0, 2'b00});
        next_step();
        reset = 1'b0;
        #1;
        chk("post_reset_idle", {1'b0, ctl}, {1'b0, C_NONE});
        next_step();
        #1;
        chk("post_reset_no_residual", {1'b0, ctl}, {1'b0, C_NONE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the vector processor's 5-stage pipeline (F/D/E/M/W). It drives the stall (enable) and clear (flush) inputs of the inter-stage pipeline registers and the E-stage forwarding selects. It resolves load-use hazards, taken-branch flushes, and multi-cycle vector ALU occupancy of the E stage. The pipeline registers only respond to stall/clear; this block decides when each is asserted.

## Interface
Parameters:
- REG_W, 4, register-address width (scalar and vector register files share encoding)
- VLAT, 4, cycles a vector ALU op occupies E (legal range 2..16)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rs1_d, rs2_d  in  REG_W  source registers of the instruction in D
- rs1_e, rs2_e  in  REG_W  source registers of the instruction in E
- rd_e, rd_m, rd_w  in  REG_W  destination registers in E/M/W
- regwrite_e, regwrite_m, regwrite_w  in  1  destination write enables
- memtoreg_e  in  1  instruction in E is a load
- vop_e  in  1  instruction in E is a multi-cycle vector op
- branch_taken_e  in  1  branch in E resolved taken
- stall_f, stall_d, stall_e  out  1  hold PC / D register / E register
- flush_d, flush_e, flush_m  out  1  clear D / E / M register to a bubble
- fwd_a_e, fwd_b_e  out  2  E operand forward select
- vbusy  out  1  vector op occupying E beyond its first cycle

## Operation
- Register 0 is the zero register and is never a forwarding or hazard match.
- Forwarding, per operand (rs1_e→fwd_a_e, rs2_e→fwd_b_e): FWD_MEM (2'b10) if regwrite_m and rd_m==rs; else FWD_WB (2'b01) if regwrite_w and rd_w==rs; else FWD_NONE (2'b00). M has priority over W.
- Load-use (lwstall): memtoreg_e and rd_e≠0 and (rd_e==rs1_d or rd_e==rs2_d). Effect: stall_f=1, stall_d=1, flush_e=1 for exactly one cycle.
- Branch: branch_taken_e. Effect: flush_d=1, flush_e=1. It overrides lwstall, so stall_f and stall_d stay 0 and the fetch redirect proceeds.
- FSM states: IDLE, VBUSY. The state register and the counter cnt (width $clog2(VLAT)) are the only state.
  - IDLE → VBUSY when vop_e=1. Load cnt=VLAT-2.
  - VBUSY: stall_f=stall_d=stall_e=1, flush_m=1, vbusy=1, and cnt decrements.
  - VBUSY → IDLE on the edge where cnt==0.
- vop_e is sampled only in IDLE. branch_taken_e and lwstall are evaluated only in IDLE; in VBUSY they are ignored and all flush_d/flush_e are 0.
- On the first E cycle of a vector op (IDLE, vop_e=1), outputs follow the normal IDLE rules.
- Back-to-back vector ops: in the IDLE cycle after VBUSY exits, vop_e=1 reloads VBUSY.

## Timing
- All outputs are combinational from current inputs plus registered state: same-cycle response, zero latency.
- A vector op holds E for exactly VLAT cycles: 1 IDLE cycle plus VLAT-1 VBUSY cycles.
- Reset: while reset=1, every output is 0 (fwd selects = FWD_NONE). On the next edge the state is IDLE and cnt=0.
- Reset asserted during VBUSY: return to IDLE on that edge and abandon the count. Outputs are 0 in the reset cycle.
- Simultaneous lwstall and branch in IDLE: branch wins. flush_d=flush_e=1, stall_f=stall_d=0.
- Simultaneous vop_e and lwstall in IDLE: both apply in that cycle, then enter VBUSY.

## Structure
- Shared package hazard_pkg:
  - enum fwd_sel_t: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - enum hz_state_t: IDLE, VBUSY
  - VLAT_MAX=16
- Sub-module hazard_fwd_sel, instantiated twice (operand A, operand B): one source register in, matching against M/W, producing a fwd_sel_t.
- Top level contains the FSM, counter, lwstall/branch logic and output priority.

## Test plan
- Forwarding: rs1_e=3, rd_m=3/regwrite_m=1, rd_w=3/regwrite_w=1 → fwd_a_e=2'b10. Drop regwrite_m → 2'b01. Set rs1_e=0 → 2'b00.
- Load-use: memtoreg_e=1, rd_e=5, rs2_d=5 → stall_f=stall_d=flush_e=1 for one cycle. Same case with rd_e=0 → all 0.
- Branch over load-use: lwstall condition plus branch_taken_e=1 → flush_d=flush_e=1, stall_f=stall_d=0.
- Vector op with VLAT=4: pulse vop_e → vbusy, stall_f/d/e and flush_m high for exactly 3 cycles, then IDLE. branch_taken_e asserted mid-VBUSY → flush_d stays 0.
- Reset mid-op: assert reset on the 2nd VBUSY cycle → all outputs 0 that cycle, IDLE next cycle, no residual stall.
- Back-to-back: vop_e=1 in the first IDLE cycle after exit → a second 3-cycle VBUSY window with no gap beyond that one cycle.
